aud_player: RTL
===============

AUD_PLAYER -- requirements
Module: aud_player

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter LRC_ACTIVE, default 1'b0, meaning the i_lrc level that selects the transmitted channel.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock (audio bit clock); all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port i_lrc, input, 1 bit: DAC left/right clock from the codec.
REQ-006 The block SHALL have port i_en, input, 1 bit: play enable.
REQ-007 The block SHALL have port i_dac_data, input, DATA_W bits: next sample, two's complement, held valid by upstream until o_sample_req.
REQ-008 The block SHALL have port o_aud_dacdat, output, 1 bit: serial DAC data, MSB first.
REQ-009 The block SHALL have port o_sample_req, output, 1 bit: one-cycle pulse when i_dac_data is consumed.
REQ-010 The block SHALL have port o_busy, output, 1 bit: high while a word is in flight (LEAD or SEND).

Function
REQ-011 The block SHALL register i_lrc every cycle into lrc_q, in all states.
REQ-012 An active edge SHALL be detected at rising edge k when lrc_q == ~LRC_ACTIVE and i_lrc == LRC_ACTIVE.
REQ-013 States SHALL be IDLE, WAIT, LEAD, SEND.
REQ-014 IDLE: o_aud_dacdat=0; when i_en=1, go to WAIT next cycle.
REQ-015 WAIT: on an active edge at edge k, latch i_dac_data into the shift register, assert o_sample_req for the cycle after edge k, and go to LEAD.
REQ-016 WAIT: when i_en=0 with no edge, return to IDLE.
REQ-017 LEAD: hold o_aud_dacdat=0 for one cycle (I2S one-bit delay), then go to SEND with bit counter = 0.
REQ-018 SEND: o_aud_dacdat SHALL equal sample bit DATA_W-1-i after edge k+1+i, for i = 0..DATA_W-1.
REQ-019 After the LSB cycle the block SHALL drive o_aud_dacdat=0 from edge k+DATA_W+1 and go to WAIT if i_en=1, else IDLE.
REQ-020 The bit counter SHALL be $clog2(DATA_W) bits wide and SHALL NOT wrap within a word; terminal count DATA_W-1 ends SEND.
REQ-021 Active edges arriving in LEAD or SEND SHALL be ignored; no re-latch and no o_sample_req.
REQ-022 Deasserting i_en in LEAD or SEND SHALL NOT truncate the word; it takes effect at the word boundary.
REQ-023 An active edge on the same cycle SEND completes SHALL NOT start a new word; the next word needs an edge detected in WAIT.
REQ-024 o_sample_req SHALL pulse exactly once per transmitted word and never in IDLE.
REQ-025 o_busy SHALL be 1 exactly in LEAD and SEND.

Reset
REQ-026 On i_rst_n=0 the block SHALL immediately force state=IDLE, o_aud_dacdat=0, o_sample_req=0, o_busy=0, shift register=0, counter=0, and lrc_q=LRC_ACTIVE (no spurious edge after release).
REQ-027 Reset asserted mid-word SHALL abort the word; after release, transmission resumes only on a fresh active edge seen in WAIT.

Structure
REQ-028 The state enum and default DATA_W SHALL live in shared package aud_pkg, which the recorder also uses.
REQ-029 The block SHALL be a single module with an inline edge detector; no sub-module is warranted.

Verification
REQ-030 Basic word: i_en=1, i_dac_data=16'hA5C3, i_lrc 1->0 -> o_sample_req pulses once; dacdat = 0 (lead), then 1010010111000011 MSB first, then 0.
REQ-031 Loopback: connect o_aud_dacdat to recorder i_data with shared i_lrc; play 14 one-hot words 16'h8000>>j -> recorder stores identical 14 words at consecutive addresses.
REQ-032 Enable drop: deassert i_en at SEND bit 5 of 16'hFFFF -> all 16 ones are sent, then IDLE, o_busy=0, and no o_sample_req on the next lrc falling edge.
REQ-033 Early lrc: toggle i_lrc 0->1->0 within 8 cycles of word start -> the word completes unaltered and there is exactly one o_sample_req.
REQ-034 Mid-word reset: assert i_rst_n=0 at SEND bit 7 -> o_aud_dacdat=0 and o_busy=0 without a clock edge; after release with i_lrc held low, no transmission until the next 1->0 lrc edge.
REQ-035 Parameter: DATA_W=24, LRC_ACTIVE=1, i_dac_data=24'h800001, i_lrc 0->1 -> lead 0, then 24 bits 1, 0x22, 1, then 0.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared audio codec definitions used by the player and the recorder.
package aud_pkg;

    localparam int AUD_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LEAD = 2'd2,
        ST_SEND = 2'd3
    } aud_state_e;

endpackage

// File: rtl/aud_player.sv
// I2S-style DAC serializer: latches one sample per active LRC edge and shifts it
// out MSB first after a one-bit lead slot.
module aud_player
    import aud_pkg::*;
#(
    parameter int   DATA_W     = AUD_DATA_W,
    parameter logic LRC_ACTIVE = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_dac_data,
    output logic              o_aud_dacdat,
    output logic              o_sample_req,
    output logic              o_busy
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    aud_state_e        state, state_nxt;
    logic              lrc_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic              act_edge;
    logic              last_bit;
    logic              load;

    assign act_edge = (lrc_q == ~LRC_ACTIVE) && (i_lrc == LRC_ACTIVE);
    assign last_bit = (bit_cnt == LAST_BIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: if (i_en) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (act_edge) begin
                    load      = 1'b1;
                    state_nxt = ST_LEAD;
                end else if (!i_en) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LEAD: state_nxt = ST_SEND;
            ST_SEND: if (last_bit) state_nxt = i_en ? ST_WAIT : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // lrc_q resets to the active level so a codec already sitting there cannot fake an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrc_q        <= LRC_ACTIVE;
            shift_q      <= '0;
            bit_cnt      <= '0;
            o_sample_req <= 1'b0;
        end else begin
            lrc_q        <= i_lrc;
            o_sample_req <= load;
            if (load) begin
                shift_q <= i_dac_data;
            end else if (state == ST_SEND) begin
                shift_q <= shift_q << 1;
            end
            if ((state == ST_SEND) && !last_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
            end
        end
    end

    assign o_aud_dacdat = (state == ST_SEND) && shift_q[DATA_W-1];
    assign o_busy       = (state == ST_LEAD) || (state == ST_SEND);

endmodule
